dmem_responder: RTL
===================

# dmem_responder

Data-side responder for the pipelined RV32 core's memory port: it accepts the core's address, write-data and write-strobe outputs and returns read data in the same cycle. The address space is decoded into a word RAM and three memory-mapped peripherals: a GPIO output register, a free-running timer, and an 8N1 UART transmitter fed by a small FIFO. It sits beside the core at SoC top level, opposite the core's memory stage.

## Interface
- RAM_WORDS, 1024: RAM depth in 32-bit words (power of 2).
- CLKS_PER_BIT, 434: clock cycles per UART bit (≥2).
- FIFO_DEPTH, 4: UART TX FIFO entries (power of 2, ≥2).

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_addr_i  in  32  byte address from core; bits [1:0] ignored.
- mem_wr_data_i  in  32  write data from core.
- mem_wr_sig_i  in  1  write strobe; one write per asserted cycle.
- mem_rd_data_o  out  32  read data, combinational from mem_addr_i.
- gpio_o  out  32  GPIO output register.
- uart_tx_o  out  1  UART serial output, idle high.

## Operation
- Address map (word-aligned):
  - addr < 4*RAM_WORDS: RAM, index addr[log2(4*RAM_WORDS)-1:2]. Read/write.
  - 0x8000_0000: GPIO. Read returns gpio_o. Write loads gpio_o.
  - 0x8000_0004: TIMER. Read returns count. Write loads count.
  - 0x8000_0008: UART. Write pushes mem_wr_data_i[7:0]. Read returns {30'b0, busy, full}.
  - Any other address: reads 0; writes ignored, no side effects.
- Reads are side-effect free. A read never pops the FIFO or clears any state.
- RAM:
  - Full-word writes only.
  - Contents are not reset and are undefined until written.
- TIMER:
  - Increments by 1 every cycle and wraps 0xFFFF_FFFF→0.
  - A write has priority over the increment: the next-cycle value equals the written data, and counting resumes from it.
- UART FIFO:
  - A push is accepted only if full=0 before the edge; otherwise the byte is silently dropped.
  - full = (count==FIFO_DEPTH).
  - Push and pop in the same cycle leave count unchanged.
- UART TX FSM: IDLE, START, DATA, STOP.
  - IDLE: uart_tx_o=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: uart_tx_o=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: uart_tx_o=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: uart_tx_o=1 for CLKS_PER_BIT cycles. At the end, pop and go to START if the FIFO is non-empty, otherwise go to IDLE.
  - busy = (state != IDLE).
- Internal counters:
  - Baud counter runs 0..CLKS_PER_BIT-1 and restarts on each bit.
  - Bit index is 3 bits wide.

## Timing
- Reset values: gpio_o=0, timer=0, uart_tx_o=1, FIFO empty (count=0), state=IDLE, baud counter=0.
- mem_rd_data_o is valid in the same cycle as mem_addr_i (zero latency).
- Writes take effect at the rising edge where mem_wr_sig_i=1.
  - A same-cycle read of the written address returns the old value.
  - The read in the following cycle returns the new value.
- UART latency:
  - A push into an empty FIFO while IDLE is popped on the next edge.
  - uart_tx_o falls 2 edges after the push edge.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames have no idle gap: STOP is followed directly by START.
- Reset asserted mid-frame:
  - uart_tx_o returns to 1 on the next edge.
  - The partial frame is abandoned and FIFO contents are discarded.
- A write to TIMER while reset=1 is ignored; reset wins over every other update.

## Test plan
- RAM access (CLKS_PER_BIT=4 for all UART tests):
  - Write 0xDEADBEEF to 0x10.
  - Same-cycle read of 0x10 returns the prior value; the next cycle returns 0xDEADBEEF.
  - 0x12 aliases to 0x10 (bits [1:0] ignored).
- Decode and GPIO:
  - Write 0x0000_00A5 to 0x8000_0000 → gpio_o=0xA5 after one edge.
  - Write to 0x4000_0000 → no state change; read of 0x4000_0000 returns 0.
- Timer:
  - Read after reset increases by 1 per cycle.
  - Write 0xFFFF_FFFE → the next reads return 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- UART single byte:
  - Push 0x55 → start bit low for 4 cycles.
  - Data bits 1,0,1,0,1,0,1,0, each 4 cycles.
  - Stop bit high for 4 cycles; total 40 cycles.
  - busy=1 throughout the frame, then 0.
- UART FIFO overflow:
  - Push 0x01..0x06 on consecutive cycles from IDLE.
  - 0x01 is popped immediately, leaving 0x02..0x05 queued, so full=1 and 0x06 is dropped.
  - Exactly 5 contiguous frames are emitted with no idle gap.
- Reset mid-frame:
  - Assert reset during DATA bit 3.
  - Next cycle: uart_tx_o=1, status reads 0, gpio_o=0, timer=0.
  - No further frames are emitted.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-side memory responder for the RV32 core: word RAM plus GPIO, timer and UART TX.
// Reads are combinational and side-effect free; all writes land on the rising edge.
module dmem_responder #(
  parameter int unsigned RAM_WORDS    = 1024,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wr_data_i,
  input  logic        mem_wr_sig_i,
  output logic [31:0] mem_rd_data_o,
  output logic [31:0] gpio_o,
  output logic        uart_tx_o
);

  localparam int unsigned RamAw = $clog2(RAM_WORDS);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);

  localparam logic [29:0] GpioWord  = 30'h2000_0000;
  localparam logic [29:0] TimerWord = 30'h2000_0001;
  localparam logic [29:0] UartWord  = 30'h2000_0002;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

  logic [29:0]      word_addr;
  logic             ram_sel, gpio_sel, timer_sel, uart_sel;
  logic [RamAw-1:0] ram_idx;
  logic             unused_addr_bits;

  assign word_addr        = mem_addr_i[31:2];
  assign ram_idx          = mem_addr_i[RamAw+1:2];
  assign ram_sel          = (mem_addr_i[31:RamAw+2] == '0);
  assign gpio_sel         = !ram_sel && (word_addr == GpioWord);
  assign timer_sel        = !ram_sel && (word_addr == TimerWord);
  assign uart_sel         = !ram_sel && (word_addr == UartWord);
  assign unused_addr_bits = ^mem_addr_i[1:0];

  logic [31:0] ram [RAM_WORDS];
  logic [31:0] gpio_q, timer_q;

  // RAM contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (mem_wr_sig_i && ram_sel) begin
      ram[ram_idx] <= mem_wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_q  <= '0;
      timer_q <= '0;
    end else begin
      if (mem_wr_sig_i && gpio_sel) gpio_q <= mem_wr_data_i;
      if (mem_wr_sig_i && timer_sel) timer_q <= mem_wr_data_i;
      else                           timer_q <= timer_q + 32'd1;
    end
  end

  // UART TX FIFO
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            full, empty, push, pop;

  assign full  = (count_q == (PtrW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign push  = mem_wr_sig_i && uart_sel && !full;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_wr_data_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // UART TX FSM; the line output is registered so it lags the state by one cycle.
  uart_state_e state_q, state_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             baud_done, busy;

  assign baud_done = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        tx_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        tx_d = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_done) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    mem_rd_data_o = '0;
    if (ram_sel)        mem_rd_data_o = ram[ram_idx];
    else if (gpio_sel)  mem_rd_data_o = gpio_q;
    else if (timer_sel) mem_rd_data_o = timer_q;
    else if (uart_sel)  mem_rd_data_o = {30'b0, busy, full};
  end

  assign gpio_o    = gpio_q;
  assign uart_tx_o = tx_q;

endmodule
